// File: rtl/fc_layer_sequencer_if.sv
// fc_layer_sequencer_if: scheduler, weight-memory and Neuron_Layer signals of fc_layer_sequencer.
interface fc_layer_sequencer_if #(
  parameter int SIZE     = 16,
  parameter int IN_SZ    = 4,
  parameter int LAYER_SZ = 2
);
  localparam int AW = (IN_SZ * LAYER_SZ > 1) ? $clog2(IN_SZ * LAYER_SZ) : 1;
  logic                       start;
  logic [0:IN_SZ-1][SIZE-1:0] in_values;
  logic                       w_rd_en;
  logic [AW-1:0]              w_rd_addr;
  logic [SIZE-1:0]            w_rd_data;
  logic                       load_en;
  logic [SIZE-1:0]            load_value;
  logic [SIZE-1:0]            load_address;
  logic                       busy;
  logic                       done;
  modport master (
    output start, in_values, w_rd_data,
    input  w_rd_en, w_rd_addr, load_en, load_value, load_address, busy, done
  );
  modport slave (
    input  start, in_values, w_rd_data,
    output w_rd_en, w_rd_addr, load_en, load_value, load_address, busy, done
  );
endinterface

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: evaluates one fully-connected layer with a streamed-weight signed MAC
// and writes each saturated (optionally ReLU-clipped) neuron result into a Neuron_Layer.
module fc_layer_sequencer #(
  parameter int SIZE     = 16,
  parameter int IN_SZ    = 4,
  parameter int LAYER_SZ = 2,
  parameter bit RELU     = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  fc_layer_sequencer_if.slave bus
);
  localparam int FRAC  = SIZE / 2;
  localparam int PW    = 2 * SIZE;
  localparam int IW    = IN_SZ * SIZE;
  localparam int AW    = (IN_SZ * LAYER_SZ > 1) ? $clog2(IN_SZ * LAYER_SZ) : 1;
  localparam int CW    = $clog2(IN_SZ + 1);
  localparam int JW    = (LAYER_SZ > 1) ? $clog2(LAYER_SZ) : 1;
  localparam int ACC_W = PW + ((IN_SZ > 1) ? $clog2(IN_SZ) : 0);
  localparam logic signed [ACC_W-1:0] VMAX = {{(ACC_W-SIZE+1){1'b0}}, {(SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] VMIN = {{(ACC_W-SIZE+1){1'b1}}, {(SIZE-1){1'b0}}};
  localparam logic [1:0] IDLE = 2'd0, MAC = 2'd1, WRITE = 2'd2, DONE = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [CW-1:0]              c_q, c_d;
  logic [JW-1:0]              j_q, j_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d, acc_mac, sh, clip;
  logic [0:IN_SZ-1][SIZE-1:0] in_q, in_d;
  logic [SIZE-1:0]            lv_q, lv_d, la_q, la_d, res;
  logic signed [PW-1:0]       prod;
  logic                       last_c, last_j;

  assign last_c = c_q == CW'(IN_SZ);
  assign last_j = j_q == JW'(LAYER_SZ - 1);

  // in_q rotates one element per product so in_q[0] always pairs with the arriving weight;
  // after IN_SZ products it is back in its latched order for the next neuron.
  always_comb begin
    prod    = PW'($signed(bus.w_rd_data)) * PW'($signed(in_q[0]));
    acc_mac = acc_q + ACC_W'(prod);
    sh      = acc_mac >>> FRAC;
    clip    = (sh > VMAX) ? VMAX : (sh < VMIN) ? VMIN : sh;
    res     = (RELU && clip < 0) ? '0 : clip[SIZE-1:0];
    state_d = state_q;
    c_d     = c_q;
    j_d     = j_q;
    acc_d   = acc_q;
    in_d    = in_q;
    lv_d    = lv_q;
    la_d    = la_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = MAC;
        in_d    = bus.in_values;
        c_d     = '0;
        j_d     = '0;
        acc_d   = '0;
      end
      MAC: begin
        state_d = last_c ? WRITE : MAC;
        c_d     = last_c ? '0 : c_q + CW'(1);
        if (c_q != '0) begin
          acc_d = acc_mac;
          in_d  = IW'({in_q, in_q} >> ((IN_SZ - 1) * SIZE));
        end
        if (last_c) begin
          lv_d = res;
          la_d = SIZE'(j_q);
        end
      end
      WRITE: begin
        state_d = last_j ? DONE : MAC;
        j_d     = last_j ? j_q : j_q + JW'(1);
        acc_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      in_q    <= '0;
      lv_q    <= '0;
      la_q    <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      in_q    <= in_d;
      lv_q    <= lv_d;
      la_q    <= la_d;
    end

  assign bus.w_rd_en      = state_q == MAC && !last_c;
  assign bus.w_rd_addr    = bus.w_rd_en ? AW'(32'(j_q) * IN_SZ + 32'(c_q)) : '0;
  assign bus.load_en      = state_q == WRITE;
  assign bus.load_value   = lv_q;
  assign bus.load_address = la_q;
  assign bus.busy         = state_q != IDLE;
  assign bus.done         = state_q == DONE;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer: directed and random runs on a plain and a ReLU instance,
// every output compared each cycle against a spec-timed arithmetic reference.
module tb_fc_layer_sequencer;
  localparam int SIZE = 16, IN = 2, L = 2, P = IN + 2, LEN = L * P + 1, AW = 2;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [0:IN-1][SIZE-1:0] in_v = '0;
  logic [SIZE-1:0] w_mem [IN*L];
  int cyc = 0, n_chk = 0, n_err = 0, ta = 0;
  bit run = 1'b0;
  logic [SIZE-1:0] lat [IN];
  logic [SIZE-1:0] exp_lv [2];
  logic [SIZE-1:0] exp_la = '0;
  logic e_busy, e_done, e_en, e_le;
  logic [AW-1:0] e_addr;
  logic [31:0] wq0 [$], wq1 [$];
  int done_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fc_layer_sequencer_if #(.SIZE(SIZE), .IN_SZ(IN), .LAYER_SZ(L)) bus0 ();
  fc_layer_sequencer_if #(.SIZE(SIZE), .IN_SZ(IN), .LAYER_SZ(L)) bus1 ();
  assign bus0.start = start;
  assign bus1.start = start;
  assign bus0.in_values = in_v;
  assign bus1.in_values = in_v;

  fc_layer_sequencer #(.SIZE(SIZE), .IN_SZ(IN), .LAYER_SZ(L), .RELU(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  fc_layer_sequencer #(.SIZE(SIZE), .IN_SZ(IN), .LAYER_SZ(L), .RELU(1'b1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  // synchronous weight memory; garbage on non-read cycles exposes mistimed sampling
  always @(posedge clk) begin
    bus0.w_rd_data <= bus0.w_rd_en ? w_mem[bus0.w_rd_addr] : SIZE'($urandom);
    bus1.w_rd_data <= bus1.w_rd_en ? w_mem[bus1.w_rd_addr] : SIZE'($urandom);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [SIZE-1:0] ref_val(input int j, input bit relu);
    longint s = 0;
    for (int k = 0; k < IN; k++)
      s += longint'($signed(w_mem[j*IN+k])) * longint'($signed(lat[k]));
    s = s >>> 8;
    s = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
    if (relu && s < 0) s = 0;
    return SIZE'(s);
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q [$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic dut_check(input int d, input logic [3:0] st, input logic [AW-1:0] ad,
                           input logic [SIZE-1:0] la, input logic [SIZE-1:0] lv);
    check($sformatf("status%0d@%0d", d, cyc), st, {e_busy, e_done, e_en, e_le});
    if (e_en || !rst_n) check($sformatf("rd_addr%0d@%0d", d, cyc), ad, e_addr);
    check($sformatf("load_out%0d@%0d", d, cyc), {la, lv}, {exp_la, exp_lv[d]});
  endtask

  // reference: run position r counts cycles from the accepting edge (r=1 is the first MAC cycle)
  always @(negedge clk) begin
    int r, j, m;
    bit idle_now;
    {e_busy, e_done, e_en, e_le} = '0;
    e_addr = '0;
    if (!rst_n) begin
      run = 1'b0;
      exp_la = '0;
      exp_lv = '{default: '0};
    end else begin
      idle_now = !run;
      if (run) begin
        r = cyc - ta + 1;
        j = (r - 1) / P;
        m = (r - 1) % P;
        e_busy = 1'b1;
        if (r == LEN) begin
          e_done = 1'b1;
          run = 1'b0;
        end else if (m < IN) begin
          e_en = 1'b1;
          e_addr = AW'(j * IN + m);
        end else if (m == P - 1) begin
          e_le = 1'b1;
          exp_la = SIZE'(j);
          exp_lv[0] = ref_val(j, 1'b0);
          exp_lv[1] = ref_val(j, 1'b1);
        end
      end
      if (idle_now && start) begin
        run = 1'b1;
        ta = cyc + 1;
        for (int k = 0; k < IN; k++) lat[k] = in_v[k];
      end
    end
    dut_check(0, {bus0.busy, bus0.done, bus0.w_rd_en, bus0.load_en}, bus0.w_rd_addr,
              bus0.load_address, bus0.load_value);
    dut_check(1, {bus1.busy, bus1.done, bus1.w_rd_en, bus1.load_en}, bus1.w_rd_addr,
              bus1.load_address, bus1.load_value);
    if (bus0.load_en) wq0.push_back({bus0.load_address, bus0.load_value});
    if (bus1.load_en) wq1.push_back({bus1.load_address, bus1.load_value});
    if (bus0.done) done_q.push_back(cyc);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic go(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    in_v[0] = a;
    in_v[1] = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4 * LEN; i++) begin
      @(negedge clk);
      if (bus0.done) break;
    end
    check("done_seen", bus0.done, 1'b1);
    tick();
  endtask

  task automatic set_w(input logic [SIZE-1:0] a, b, c, d);
    w_mem[0] = a; w_mem[1] = b; w_mem[2] = c; w_mem[3] = d;
  endtask

  task automatic clear_q();
    wq0.delete();
    wq1.delete();
    done_q.delete();
  endtask

  task automatic check_pair(input string tag, input logic [15:0] v0, v1, r0, r1);
    check({tag, "_n"}, wq0.size(), 2);
    check({tag, "_w0"}, at(wq0, 0), {16'd0, v0});
    check({tag, "_w1"}, at(wq0, 1), {16'd1, v1});
    check({tag, "_r0"}, at(wq1, 0), {16'd0, r0});
    check({tag, "_r1"}, at(wq1, 1), {16'd1, r1});
  endtask

  function automatic logic [SIZE-1:0] rnd_val();
    return $urandom_range(0, 1) ? SIZE'($urandom) : SIZE'($urandom_range(0, 1023) - 512);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_w('0, '0, '0, '0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    // basic and ReLU
    clear_q();
    set_w(16'h0100, 16'h0100, 16'h0080, 16'hFF00);
    go(16'h0100, 16'h0200);
    wait_done();
    check_pair("basic", 16'h0300, 16'hFE80, 16'h0300, 16'h0000);
    // saturation both ways
    clear_q();
    set_w(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
    go(16'h7F00, 16'h7F00);
    wait_done();
    check_pair("sat_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    clear_q();
    set_w(16'h8100, 16'h8100, 16'h8100, 16'h8100);
    go(16'h7F00, 16'h7F00);
    wait_done();
    check_pair("sat_neg", 16'h8000, 16'h8000, 16'h0000, 16'h0000);
    // inputs latched, mid-run start ignored
    clear_q();
    set_w(16'h0100, 16'h0100, 16'h0080, 16'hFF00);
    go(16'h0100, 16'h0200);
    tick(3);
    in_v = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    tick(3);
    check_pair("latch", 16'h0300, 16'hFE80, 16'h0300, 16'h0000);
    check("latch_dones", done_q.size(), 1);
    // reset during neuron 1 MAC
    clear_q();
    go(16'h0100, 16'h0200);
    tick(5);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("rst_writes", wq0.size(), 1);
    check("rst_w0", at(wq0, 0), {16'd0, 16'h0300});
    check("rst_dones", done_q.size(), 0);
    clear_q();
    go(16'h0100, 16'h0200);
    wait_done();
    check_pair("restart", 16'h0300, 16'hFE80, 16'h0300, 16'h0000);
    // back-to-back with start held
    clear_q();
    in_v[0] = 16'h0100;
    in_v[1] = 16'h0200;
    start = 1'b1;
    repeat (3) wait_done();
    start = 1'b0;
    tick(2);
    check("b2b_writes", wq0.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("b2b_addr%0d", i), at(wq0, i) >> 16, i % 2);
    check("b2b_dones", done_q.size(), 3);
    for (int i = 1; i < 3; i++)
      check($sformatf("b2b_gap%0d", i),
            (done_q.size() > i) ? done_q[i] - done_q[i-1] : -1, L * P + 2);
    // random runs, with mid-run noise on start/in_values and occasional resets
    for (int n = 0; n < 30; n++) begin
      for (int a = 0; a < IN * L; a++) w_mem[a] = rnd_val();
      tick($urandom_range(0, 2));
      go(rnd_val(), rnd_val());
      if ($urandom_range(0, 7) == 0) begin
        tick($urandom_range(1, LEN - 1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          tick($urandom_range(0, LEN - 3));
          in_v[0] = rnd_val();
          in_v[1] = rnd_val();
          start = 1'b1;
          tick();
          start = 1'b0;
        end
        wait_done();
      end
    end
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fc_layer_sequencer.md
# fc_layer_sequencer

Sequences one fully-connected layer evaluation into a `Neuron_Layer`. It latches an input activation vector on `start`, streams weights from an external synchronous weight memory, and multiply-accumulates in signed Q8.8. Each output neuron's saturated, optionally ReLU-clipped result is written into the neuron layer through its `load_en`/`load_value`/`load_address` port. It sits between the layer-level scheduler and the `Neuron_Layer` register bank.

## Interface
- `SIZE`, 16, data width; signed Q8.8 when 16 (`FRAC` = `SIZE`/2 fraction bits)
- `IN_SZ`, 4, number of input activations per neuron
- `LAYER_SZ`, 2, number of output neurons (matches `Neuron_Layer` `LAYER_SZ`)
- `RELU`, 0, 1 = clamp negative results to 0 before write
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin evaluation; sampled only in IDLE
- `in_values`  in  `[0:IN_SZ-1][SIZE-1:0]`  input activations; latched on accepted `start`
- `w_rd_en`  out  1  weight read strobe
- `w_rd_addr`  out  `$clog2(IN_SZ*LAYER_SZ)`  weight address = j*IN_SZ + k
- `w_rd_data`  in  `SIZE`  weight data, valid exactly 1 cycle after `w_rd_en`
- `load_en`  out  1  write strobe to `Neuron_Layer`
- `load_value`  out  `SIZE`  neuron result
- `load_address`  out  `SIZE`  neuron index j (zero-extended)
- `busy`  out  1  high from cycle after accepted `start` until DONE ends
- `done`  out  1  one-cycle pulse after last neuron written

## Operation
- FSM states: IDLE, MAC, WRITE, DONE.
- IDLE: `start`=1 latches `in_values` into internal regs, j=0, k=0, acc=0 → MAC. `start` is ignored in all other states.
- MAC lasts IN_SZ+1 cycles per neuron, counter c=0..IN_SZ:
  - c<IN_SZ: `w_rd_en`=1, `w_rd_addr`=j*IN_SZ+c.
  - c≥1: acc += `w_rd_data` × latched in[c-1], as a signed full product.
  - After c=IN_SZ → WRITE.
- WRITE, one cycle:
  - `load_en`=1, `load_address`=j, `load_value`=sat(acc >>> FRAC).
  - If RELU and result<0, `load_value`=0.
  - If j=LAYER_SZ-1 → DONE; else j++, acc=0 → MAC.
- DONE, one cycle: `done`=1 → IDLE.
- Arithmetic:
  - Product width 2·SIZE.
  - acc width 2·SIZE+$clog2(IN_SZ), no overflow possible.
  - Shift is arithmetic (floor).
  - Saturate to [−2^(SIZE−1), 2^(SIZE−1)−1], i.e. 0x8000..0x7FFF for SIZE=16.
- `load_value`/`load_address` hold last written values when `load_en`=0; they are only meaningful with `load_en`.
- `in_values` may change freely after `start` is accepted; only the latched copy is used.

## Timing
- Reset (async assert, sync deassert by system): state=IDLE, j=c=acc=0.
  - `w_rd_en`=`load_en`=`busy`=`done`=0, `w_rd_addr`=0, `load_value`=0, `load_address`=0.
- Reset mid-run aborts immediately; no partial `load_en` issued. Restart requires a new `start`.
- `start` accepted at edge T: first `w_rd_en` in cycle T+1.
- First `load_en` at cycle T+IN_SZ+2; subsequent writes every IN_SZ+2 cycles.
- `done` in cycle T+LAYER_SZ·(IN_SZ+2)+1; `busy` falls with it. Next `start` is accepted in the following IDLE cycle.
- `start` held high continuously: restarts one cycle after `done`; no back-to-back overlap.
- Exactly LAYER_SZ `load_en` pulses per run, addresses 0..LAYER_SZ-1 ascending, never repeated.

## Test plan
- Basic (IN_SZ=2, LAYER_SZ=2, RELU=0): in={0x0100,0x0200}, weights[0..3]={0x0100,0x0100,0x0080,0xFF00} → writes (addr 0, 0x0300) then (addr 1, 0xFE80); `done` at T+9; read addrs 0,1,2,3 on consecutive MAC cycles.
- Saturation: in={0x7F00,0x7F00}, weights all 0x7F00 → both writes 0x7FFF. Weights all 0x8100 → both writes 0x8000.
- ReLU (RELU=1), Basic stimulus → writes 0x0300, 0x0000.
- Input latch / busy ignore: change `in_values` to 0 and pulse `start` mid-run → results unchanged from Basic; exactly 2 `load_en` pulses; one `done`.
- Reset mid-run: assert `rst_n`=0 during neuron 1 MAC → all outputs 0 the same cycle, no write to addr 1. Restart → full Basic results.
- Back-to-back: `start` held high for 3 runs → 6 writes, addresses 0,1,0,1,0,1; `done` spacing = LAYER_SZ·(IN_SZ+2)+2 cycles.
